led_matrix_scanner: RTL and testbench

Parametrised, double-buffered column-scan driver for ROWS x COLS LED matrices with per-slot anti-ghost blanking and global brightness PWM. Sits between the glyph/frame-composition logic and the matrix pins. It accepts a full frame through a valid/ready handshake and swaps it in only at a frame boundary, so the display never tears.

---
 rtl/led_matrix_pkg.sv | 19 +
 rtl/led_matrix_frame_buf.sv | 61 ++++++
 rtl/led_matrix_scanner.sv | 185 ++++++++++++++++++
 tb/tb_led_matrix_scanner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg
// Shared definitions for the LED matrix column scanner.
//   scan_state_e : scanner FSM states (OFF, BLANK, DRIVE)
//   pix_idx      : flat index of pixel (r, c) in a row-major frame vector
package led_matrix_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

  function automatic int unsigned pix_idx(input int unsigned r,
                                          input int unsigned c,
                                          input int unsigned cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/led_matrix_frame_buf.sv
// led_matrix_frame_buf
// Double buffer for the scanner: a shadow register accepts a new frame through
// a valid/ready handshake, and the display register only takes it over when
// the scanner requests a swap at a frame boundary.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   frame_in     : incoming frame, bit r*COLS+c = pixel (r, c)
//   frame_valid  : frame_in offered
//   swap_req     : scanner is at a point where the display may change
//   frame_ready  : shadow buffer free (registered, = !pending)
//   display      : frame currently being scanned out
module led_matrix_frame_buf
  import led_matrix_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROWS*COLS-1:0] frame_in,
  input  logic                 frame_valid,
  input  logic                 swap_req,
  output logic                 frame_ready,
  output logic [ROWS*COLS-1:0] display
);

  logic [ROWS*COLS-1:0] shadow_q, shadow_d;
  logic [ROWS*COLS-1:0] display_q, display_d;
  logic                 pending_q, pending_d;

  // Accept only while the shadow is empty; swap only while it is full, so the
  // two updates can never collide in the same cycle.
  always_comb begin
    shadow_d  = shadow_q;
    display_d = display_q;
    pending_d = pending_q;
    if (frame_valid && !pending_q) begin
      shadow_d  = frame_in;
      pending_d = 1'b1;
    end else if (swap_req && pending_q) begin
      display_d = shadow_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= '0;
      display_q <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      display_q <= display_d;
      pending_q <= pending_d;
    end
  end

  assign frame_ready = !pending_q;
  assign display     = display_q;

endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
// Double-buffered column-scan driver for a ROWS x COLS LED matrix. Each column
// slot lasts DIV cycles: one BLANK cycle (anti-ghosting, all pins inactive)
// followed by DIV-1 DRIVE cycles. New frames are swapped in only at the end of
// the last column so the picture never tears.
// Optional feature macro: LED_MATRIX_PWM_EN enables global brightness PWM
// within the DRIVE cycles; without it the brightness port is ignored.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   en           : scan enable
//   an           : pin polarity (0: rows high-to-light, selected column low)
//   frame_in     : frame data, bit r*COLS+c = pixel (r, c), 1 = lit
//   frame_valid  : frame_in offered;  frame_ready : shadow buffer free
//   brightness   : PWM duty level, 0 = dark
//   rows         : row drive;  colms : column select (column c on colms[COLS-1-c])
//   frame_start  : one-cycle pulse marking the first cycle of each frame
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int DIV      = 1000,
  parameter int PWM_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 an,
  input  logic [ROWS*COLS-1:0] frame_in,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  input  logic [PWM_BITS-1:0]  brightness,
  output logic [ROWS-1:0]      rows,
  output logic [COLS-1:0]      colms,
  output logic                 frame_start
);

  localparam int SW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(DIV - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);

  scan_state_e          state_q, state_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic [CW-1:0]        col_q, col_d;
  logic [ROWS-1:0]      rows_q, rows_d;
  logic [COLS-1:0]      colms_q, colms_d;
  logic                 frame_start_q, frame_start_d;
  logic [ROWS*COLS-1:0] display;
  logic                 swap_req;
  logic                 lit;

  // While disabled any pending frame can go straight to the display; while
  // scanning it waits for the last cycle of the last column.
  assign swap_req = !en ||
                    (state_q == DRIVE && slot_q == SLOT_LAST && col_q == COL_LAST);

  led_matrix_frame_buf #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_frame_buf (
    .clk         (clk),
    .rst         (rst),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .swap_req    (swap_req),
    .frame_ready (frame_ready),
    .display     (display)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      slot_q  <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF:     state_d = BLANK;
        BLANK:   state_d = DRIVE;
        DRIVE:   if (slot_q == SLOT_LAST) state_d = BLANK;
        default: state_d = OFF;
      endcase
    end
  end

  // The OFF cycle holds the counters at zero so the first BLANK after enable
  // always belongs to column 0, slot 0.
  always_comb begin
    slot_d = slot_q;
    col_d  = col_q;
    if (!en || state_q == OFF) begin
      slot_d = '0;
      col_d  = '0;
    end else if (slot_q == SLOT_LAST) begin
      slot_d = '0;
      col_d  = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
    end else begin
      slot_d = slot_q + SW'(1);
    end
  end

`ifdef LED_MATRIX_PWM_EN
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] bright_q, bright_d;

  // Brightness is sampled once per slot in BLANK so a change never splits a
  // slot between two duty levels.
  always_comb begin
    pwm_d    = pwm_q;
    bright_d = bright_q;
    if (state_q == BLANK) begin
      pwm_d    = '0;
      bright_d = brightness;
    end else if (state_q == DRIVE) begin
      pwm_d = pwm_q + PWM_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q    <= '0;
      bright_q <= '0;
    end else begin
      pwm_q    <= pwm_d;
      bright_q <= bright_d;
    end
  end

  assign lit = (pwm_q < bright_q);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign lit = 1'b1;
`endif

  // Pins are computed from the current state and registered, so they trail
  // the FSM by one cycle.
  always_comb begin
    rows_d        = {ROWS{an}};
    colms_d       = {COLS{~an}};
    frame_start_d = 1'b0;
    case (state_q)
      BLANK: frame_start_d = en && (col_q == '0);
      DRIVE: begin
        for (int c = 0; c < COLS; c++) begin
          if (col_q == CW'(c)) begin
            colms_d[COLS-1-c] = an;
            for (int r = 0; r < ROWS; r++) begin
              rows_d[r] = (display[pix_idx(r, c, COLS)] && lit) ^ an;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q        <= {ROWS{an}};
      colms_q       <= {COLS{~an}};
      frame_start_q <= 1'b0;
    end else begin
      rows_q        <= rows_d;
      colms_q       <= colms_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign rows        = rows_q;
  assign colms       = colms_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner
// Directed bench for led_matrix_scanner with ROWS=8, COLS=8, DIV=4, PWM_BITS=2.
// Inputs change 1 ns after each rising edge and outputs are sampled there too.
// Expected pins for scan state s (0 = first BLANK after enable) come from the
// slot/column arithmetic: slot = s%4, col = (s/4)%8, frame start when s%32==0.
module tb_led_matrix_scanner;

  localparam int ROWS     = 8;
  localparam int COLS     = 8;
  localparam int DIV      = 4;
  localparam int PWM_BITS = 2;

  localparam logic [63:0] FRAME_A = 64'h0000_0000_0000_0001;
  localparam logic [63:0] FRAME_B = 64'h0000_0000_0000_FF00;
  localparam logic [63:0] FRAME_C = 64'hFFFF_FFFF_FFFF_FFFF;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 an;
  logic [ROWS*COLS-1:0] frame_in;
  logic                 frame_valid;
  logic                 frame_ready;
  logic [PWM_BITS-1:0]  brightness;
  logic [ROWS-1:0]      rows;
  logic [COLS-1:0]      colms;
  logic                 frame_start;

  int vecCount  = 0;
  int missCount = 0;
  int brightAt[0:255];

  always #5 clk = ~clk;

  led_matrix_scanner #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .DIV      (DIV),
    .PWM_BITS (PWM_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .an          (an),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .brightness  (brightness),
    .rows        (rows),
    .colms       (colms),
    .frame_start (frame_start)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] colBits(input logic [63:0] frm, input int c);
    logic [7:0] b;
    for (int r = 0; r < 8; r++) b[r] = frm[r*8+c];
    return b;
  endfunction

  // Drives the inputs for scan state s. With sched set, frame B is offered
  // mid-frame, frame C is offered while the shadow is still full, and the
  // brightness is stepped down part-way through a slot.
  task automatic applyStimulus(input int s, input bit sched);
    en = 1'b1;
    if (s == -1) brightness = 2'd3;
    if (sched) begin
      case (s)
        41:      begin frame_in = FRAME_B; frame_valid = 1'b1; end
        42:      frame_valid = 1'b0;
        45:      begin frame_in = FRAME_C; frame_valid = 1'b1; end
        49:      frame_valid = 1'b0;
        126:     brightness = 2'd1;
        190:     brightness = 2'd0;
        default: ;
      endcase
    end
  endtask

  // Offers a frame while scanning is disabled: accepted on the first edge,
  // moved to the display on the next.
  task automatic loadIdle(input logic [63:0] f);
    en          = 1'b0;
    frame_in    = f;
    frame_valid = 1'b1;
    tick();
    checkOutput("ready after idle offer", {63'd0, frame_ready}, 64'd0);
    frame_valid = 1'b0;
    tick();
    checkOutput("ready after idle swap", {63'd0, frame_ready}, 64'd1);
  endtask

  // Iteration s=-1 is the OFF cycle in which en rises; after the edge of
  // iteration s the pins show scan state s.
  task automatic runScan(input int lastS, input bit sched,
                         input logic [63:0] frm, input bit anV);
    logic [7:0]  expRows;
    logic [7:0]  expCols;
    logic        expStart;
    logic        expReady;
    logic        lit;
    logic [63:0] shown;
    int          slot;
    int          col;
    int          lb;
    for (int s = -1; s <= lastS; s++) begin
      applyStimulus(s, sched);
      if (s >= 0) brightAt[s] = int'(brightness);
      tick();
      if (s < 0) begin
        expRows  = 8'h00;
        expCols  = 8'hFF;
        expStart = 1'b0;
      end else begin
        slot     = s % 4;
        col      = (s / 4) % 8;
        lb       = brightAt[s - slot];
        shown    = (sched && s >= 64) ? FRAME_B : frm;
        expStart = (s % 32 == 0);
        if (slot == 0) begin
          expRows = 8'h00;
          expCols = 8'hFF;
        end else begin
`ifdef LED_MATRIX_PWM_EN
          lit = ((slot - 1) < lb);
`else
          lit = 1'b1;
`endif
          expRows = lit ? colBits(shown, col) : 8'h00;
          expCols = ~(8'h80 >> col);
        end
      end
      expReady = !(sched && s >= 41 && s <= 62);
      expRows  = expRows ^ {8{anV}};
      expCols  = expCols ^ {8{anV}};
      checkOutput($sformatf("rows s=%0d", s), {56'd0, rows}, {56'd0, expRows});
      checkOutput($sformatf("colms s=%0d", s), {56'd0, colms}, {56'd0, expCols});
      checkOutput($sformatf("frame_start s=%0d", s), {63'd0, frame_start},
                  {63'd0, expStart});
      checkOutput($sformatf("frame_ready s=%0d", s), {63'd0, frame_ready},
                  {63'd0, expReady});
    end
  endtask

  initial begin
    rst         = 1'b1;
    en          = 1'b0;
    an          = 1'b0;
    frame_valid = 1'b0;
    frame_in    = '0;
    brightness  = 2'd3;
    tick();
    tick();
    $display("[TB] reset values, an=0");
    checkOutput("reset rows", {56'd0, rows}, 64'h00);
    checkOutput("reset colms", {56'd0, colms}, 64'hFF);
    checkOutput("reset frame_ready", {63'd0, frame_ready}, 64'd1);
    checkOutput("reset frame_start", {63'd0, frame_start}, 64'd0);
    rst = 1'b0;

    $display("[TB] scan frame A, swap to B mid-run, brightness steps");
    loadIdle(FRAME_A);
    runScan(223, 1'b1, FRAME_A, 1'b0);

    $display("[TB] disable and re-enable");
    en = 1'b0;
    tick();
    tick();
    checkOutput("disabled rows", {56'd0, rows}, 64'h00);
    checkOutput("disabled colms", {56'd0, colms}, 64'hFF);
    checkOutput("disabled frame_start", {63'd0, frame_start}, 64'd0);
    runScan(40, 1'b0, FRAME_B, 1'b0);

    $display("[TB] inverted polarity an=1");
    en  = 1'b0;
    an  = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    checkOutput("an1 reset rows", {56'd0, rows}, 64'hFF);
    checkOutput("an1 reset colms", {56'd0, colms}, 64'h00);
    checkOutput("an1 reset frame_ready", {63'd0, frame_ready}, 64'd1);
    checkOutput("an1 reset frame_start", {63'd0, frame_start}, 64'd0);
    rst = 1'b0;
    loadIdle(FRAME_A);
    runScan(40, 1'b0, FRAME_A, 1'b1);

    $display("[TB] reset mid-scan with a pending frame");
    en  = 1'b0;
    an  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    loadIdle(FRAME_A);
    runScan(10, 1'b0, FRAME_A, 1'b0);
    frame_in    = FRAME_C;
    frame_valid = 1'b1;
    tick();
    checkOutput("pending before reset", {63'd0, frame_ready}, 64'd0);
    frame_valid = 1'b0;
    rst         = 1'b1;
    tick();
    checkOutput("mid reset frame_ready", {63'd0, frame_ready}, 64'd1);
    checkOutput("mid reset rows", {56'd0, rows}, 64'h00);
    checkOutput("mid reset colms", {56'd0, colms}, 64'hFF);
    checkOutput("mid reset frame_start", {63'd0, frame_start}, 64'd0);
    rst = 1'b0;
    runScan(70, 1'b0, 64'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
